// File: rtl/or1200_enc_seed_buf_if.sv
// Seed buffer bus: pipeline-side push triplet plus load/store engine handshakes.
interface or1200_enc_seed_buf_if #(
  parameter int unsigned AW = 2
);
  logic [31:0] seedIn;
  logic [4:0]  seedAddr;
  logic [10:0] seedImm;
  logic        seed_read;
  logic        full;
  logic        load_valid;
  logic        load_ready;
  logic        store_valid;
  logic        store_ready;
  logic [31:0] seedIn_out;
  logic [4:0]  seedAddr_out;
  logic [10:0] seedImm_out;
  logic [AW:0] count;
  logic        overflow;

  modport master (
    output seedIn, seedAddr, seedImm, seed_read, load_ready, store_ready,
    input  full, load_valid, store_valid, seedIn_out, seedAddr_out, seedImm_out,
           count, overflow
  );

  modport slave (
    input  seedIn, seedAddr, seedImm, seed_read, load_ready, store_ready,
    output full, load_valid, store_valid, seedIn_out, seedAddr_out, seedImm_out,
           count, overflow
  );
endinterface

// File: rtl/or1200_enc_seed_buf.sv
// Seed triplet FIFO feeding the load/store encryption engines, routed by seedImm[10].
// Optional same-cycle bypass when empty: define OR1200_ENC_SEED_BUF_BYPASS_EN.
module or1200_enc_seed_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input logic                    clk,
  input logic                    rst,
  or1200_enc_seed_buf_if.slave   bus
);

  typedef struct packed {
    logic [10:0] imm;
    logic [4:0]  addr;
    logic [31:0] seed;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          ovf;

  entry_t din;
  entry_t stored;
  entry_t head;
  logic   head_vld;
  logic   empty;
  logic   full_c;
  logic   lv;
  logic   sv;
  logic   sel_pop;
  logic   pop;
  logic   push;
  logic   drop;

  assign din    = {bus.seedImm, bus.seedAddr, bus.seedIn};
  assign stored = mem[rd_ptr];
  assign empty  = (cnt == '0);
  assign full_c = (cnt == (AW+1)'(DEPTH));

`ifdef OR1200_ENC_SEED_BUF_BYPASS_EN
  logic byp;
  assign byp = rst & empty & bus.seed_read;

  // Incoming triplet is presented directly while the queue is empty
  always_comb begin
    head     = '0;
    head_vld = 1'b0;
    if (byp) begin
      head     = din;
      head_vld = 1'b1;
    end else if (!empty) begin
      head     = stored;
      head_vld = 1'b1;
    end
  end
`else
  assign head     = empty ? '0 : stored;
  assign head_vld = !empty;
`endif

  assign lv      = head_vld &  head.imm[10];
  assign sv      = head_vld & !head.imm[10];
  assign sel_pop = (lv & bus.load_ready) | (sv & bus.store_ready);

`ifdef OR1200_ENC_SEED_BUF_BYPASS_EN
  // A bypassed triplet that is accepted never touches storage
  assign pop  = sel_pop & !byp;
  assign push = bus.seed_read & (!full_c | sel_pop) & !(byp & sel_pop);
`else
  assign pop  = sel_pop;
  assign push = bus.seed_read & (!full_c | pop);
`endif

  assign drop = bus.seed_read & full_c & !sel_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  // Entry storage is intentionally left uninitialised by reset
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= din;
  end

  assign bus.full         = full_c;
  assign bus.load_valid   = lv;
  assign bus.store_valid  = sv;
  assign bus.seedIn_out   = head.seed;
  assign bus.seedAddr_out = head.addr;
  assign bus.seedImm_out  = head.imm;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;

endmodule

// File: tb/tb_or1200_enc_seed_buf.sv
// Directed vector bench for or1200_enc_seed_buf (routing, full/drop, wrap, bypass latency).
module tb_or1200_enc_seed_buf;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  or1200_enc_seed_buf_if #(.AW(2)) bus ();

  or1200_enc_seed_buf #(.DEPTH(4), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rd;
    logic [31:0] din;
    logic [4:0]  addr;
    logic [10:0] imm;
    logic        lr;
    logic        sr;
    logic        chk;
    logic        e_full;
    logic        e_lv;
    logic        e_sv;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    logic [10:0] e_imm;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void row(input logic r, input logic rd, input logic [31:0] d,
                              input logic [4:0] a, input logic [10:0] im,
                              input logic lr, input logic sr, input logic chk,
                              input logic ef, input logic elv, input logic esv,
                              input logic [2:0] ec, input logic eo,
                              input logic [10:0] eim, input logic [31:0] ed);
    vec_t v;
    v.rst = r; v.rd = rd; v.din = d; v.addr = a; v.imm = im; v.lr = lr; v.sr = sr;
    v.chk = chk; v.e_full = ef; v.e_lv = elv; v.e_sv = esv; v.e_cnt = ec;
    v.e_ovf = eo; v.e_imm = eim; v.e_dout = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] d,
                       input logic [4:0] a, input logic [10:0] im,
                       input logic lr, input logic sr);
    rst = r; bus.seed_read = rd; bus.seedIn = d; bus.seedAddr = a; bus.seedImm = im;
    bus.load_ready = lr; bus.store_ready = sr;
  endtask

  function automatic logic [63:0] status();
    return 64'({bus.full, bus.load_valid, bus.store_valid, bus.count, bus.overflow,
                bus.seedImm_out, bus.seedIn_out});
  endfunction

  initial begin
    passed = 0;
    total  = 0;
    drive(1'b0, 1'b1, 32'h55AA55AA, 5'd9, 11'h400, 1'b0, 1'b0);

    // Reset held two cycles with seed_read high
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset", status(), 64'd0);
    check("reset_addr", 64'(bus.seedAddr_out), 64'd0);

    // Routing
    row(1,1,32'hDEADBEEF,5'd3,11'h400,0,0, 0, 0,0,0,0,0,11'h000,32'h0);
    row(1,1,32'h12345678,5'd7,11'h005,0,0, 1, 0,1,0,1,0,11'h400,32'hDEADBEEF);
    row(1,0,32'h0,5'd0,11'h000,1,0, 1, 0,1,0,2,0,11'h400,32'hDEADBEEF);
    row(1,0,32'h0,5'd0,11'h000,1,0, 1, 0,0,1,1,0,11'h005,32'h12345678);
    row(1,0,32'h0,5'd0,11'h000,0,1, 1, 0,0,1,1,0,11'h005,32'h12345678);
    row(1,0,32'h0,5'd0,11'h000,0,0, 1, 0,0,0,0,0,11'h000,32'h0);
    // Fill to full, then a dropped fifth push
    for (int i = 0; i < 5; i++)
      row(1,1,32'hA0000000 + 32'(i),5'(i),11'h0F0,0,0, (i != 0),
          (i == 4),0,(i != 0),3'(i),0,(i != 0) ? 11'h0F0 : 11'h000,
          (i != 0) ? 32'hA0000000 : 32'h0);
    row(1,0,32'h0,5'd0,11'h000,0,0, 1, 1,0,1,4,1,11'h0F0,32'hA0000000);
    // Mid-operation reset discards entries and clears overflow
    row(0,0,32'h0,5'd0,11'h000,0,0, 1, 1,0,1,4,1,11'h0F0,32'hA0000000);
    row(1,0,32'h0,5'd0,11'h000,0,0, 1, 0,0,0,0,0,11'h000,32'h0);
    // Refill, then push+pop while full, then drain
    for (int i = 0; i < 4; i++)
      row(1,1,32'hB0000000 + 32'(i),5'(i),11'h0F0,0,0, (i != 0),
          0,0,(i != 0),3'(i),0,(i != 0) ? 11'h0F0 : 11'h000,
          (i != 0) ? 32'hB0000000 : 32'h0);
    row(1,1,32'hB0000004,5'd4,11'h0F0,0,1, 1, 1,0,1,4,0,11'h0F0,32'hB0000000);
    for (int k = 1; k < 5; k++)
      row(1,0,32'h0,5'd0,11'h000,0,1, 1, (k == 1),0,1,3'(5 - k),0,11'h0F0,
          32'hB0000000 + 32'(k));
    row(1,0,32'h0,5'd0,11'h000,0,0, 1, 0,0,0,0,0,11'h000,32'h0);

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].rst, vecs[n].rd, vecs[n].din, vecs[n].addr, vecs[n].imm,
            vecs[n].lr, vecs[n].sr);
      #1;
      if (vecs[n].chk)
        check($sformatf("vec%0d", n), status(),
              64'({vecs[n].e_full, vecs[n].e_lv, vecs[n].e_sv, vecs[n].e_cnt,
                   vecs[n].e_ovf, vecs[n].e_imm, vecs[n].e_dout}));
    end

    // Wrap-around: alternating load/store seeds, pointers wrap twice
    for (int i = 0; i < 10; i++) begin
      logic ld;
      ld = ((i % 2) == 0);
      @(negedge clk);
      drive(1'b1, 1'b1, 32'(i), 5'(i), ld ? (11'h400 | 11'(i)) : 11'(i), 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0, 5'd0, 11'h000, ld, !ld);
      #1;
      check($sformatf("wrap%0d", i),
            64'({bus.load_valid, bus.store_valid, bus.seedAddr_out, bus.seedIn_out, bus.count}),
            64'({ld, !ld, 5'(i), 32'(i), 3'd1}));
    end

    // Latency with empty buffer and selected ready already high
    @(negedge clk);
    drive(1'b1, 1'b1, 32'hCAFEF00D, 5'd1, 11'h400, 1'b1, 1'b0);
    #1;
`ifdef OR1200_ENC_SEED_BUF_BYPASS_EN
    check("byp_same", 64'({bus.load_valid, bus.seedIn_out, bus.count}),
          64'({1'b1, 32'hCAFEF00D, 3'd0}));
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 5'd0, 11'h000, 1'b0, 1'b0);
    #1;
    check("byp_next", 64'({bus.load_valid, bus.count}), 64'({1'b0, 3'd0}));
    // Bypass presented but not accepted is queued
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0BADF00D, 5'd2, 11'h001, 1'b0, 1'b0);
    #1;
    check("byp_hold", 64'({bus.store_valid, bus.seedIn_out, bus.count}),
          64'({1'b1, 32'h0BADF00D, 3'd0}));
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 5'd0, 11'h000, 1'b0, 1'b1);
    #1;
    check("byp_queued", 64'({bus.store_valid, bus.seedIn_out, bus.count}),
          64'({1'b1, 32'h0BADF00D, 3'd1}));
`else
    check("lat_same", 64'({bus.load_valid, bus.seedIn_out, bus.count}),
          64'({1'b0, 32'h0, 3'd0}));
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 5'd0, 11'h000, 1'b1, 1'b0);
    #1;
    check("lat_next", 64'({bus.load_valid, bus.seedIn_out, bus.seedAddr_out, bus.count}),
          64'({1'b1, 32'hCAFEF00D, 5'd1, 3'd1}));
`endif
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 5'd0, 11'h000, 1'b0, 1'b0);
    #1;
    check("final_empty", status(), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
